// File: rtl/sha_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha_pad_pkg
// Brief    : Shared constants and FSM state type for the SHA block padder.
// Revision : 1.0 - initial release
// ============================================================================
package sha_pad_pkg;

    localparam int        BLOCK_BYTES     = 64;
    localparam int        LEN_FIELD_BYTES = 8;
    localparam logic [7:0] PAD_BYTE       = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2,
        XTRA = 2'd3
    } pad_state_t;

endpackage : sha_pad_pkg
`default_nettype wire

// File: rtl/sha_pad_tail.sv
`default_nettype none
// ============================================================================
// Module   : sha_pad_tail
// Brief    : Inserts the 0x80 pad byte and the 64-bit length field into a block.
// Revision : 1.0 - initial release
// ============================================================================
module sha_pad_tail
    import sha_pad_pkg::*;
(
    input  logic [511:0] blk_in,
    input  logic [6:0]   pad_pos,
    input  logic         pad_en,
    input  logic [63:0]  bit_len,
    output logic [511:0] blk_out,
    output logic         need_extra
);

    localparam logic [6:0] c_last_pad_pos = 7'(BLOCK_BYTES - LEN_FIELD_BYTES - 1);

    always_comb begin
        blk_out    = blk_in;
        need_extra = (pad_pos > c_last_pad_pos);
        // pad_pos of 64 means the pad byte spills into the following block
        if (pad_en && !pad_pos[6]) begin
            blk_out[{~pad_pos[5:0], 3'b000} +: 8] = PAD_BYTE;
        end
        if (!need_extra) begin
            blk_out[63:0] = bit_len;
        end
    end

endmodule : sha_pad_tail
`default_nettype wire

// File: rtl/sha_block_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha_block_padder
// Brief    : Packs a byte stream into SHA-padded 512-bit blocks.
//            Define SHA_PAD_LEN_CHECK_EN to add the err output for oversize lengths.
// Revision : 1.0 - initial release
// ============================================================================
module sha_block_padder
    import sha_pad_pkg::*;
#(
    parameter  int MAX_MESSAGE_LENGTH = 1024,
    localparam int LEN_W = $clog2(MAX_MESSAGE_LENGTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_length,
    input  logic [7:0]       msg_data,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic [511:0]     blk_data,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             blk_last,
`ifdef SHA_PAD_LEN_CHECK_EN
    output logic             err,
`endif
    output logic             busy
);

    pad_state_t       r_state;
    pad_state_t       w_state_nxt;
    logic [511:0]     r_buf;
    logic [511:0]     w_fill_blk;
    logic [511:0]     w_tail_in;
    logic [511:0]     w_tail_out;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_byte_cnt;
    logic [LEN_W-1:0] r_blk_cnt;
    logic [LEN_W-1:0] w_cnt_next;
    logic             r_last;
    logic             r_xtra_pend;
    logic             r_pad_pend;
    logic [5:0]       w_pos;
    logic             w_last_byte;
    logic             w_need_extra;
    logic             w_len_bad;
    logic             w_start_ok;
    logic             w_err_nxt;
    logic [6:0]       w_pad_pos;
    logic             w_pad_en;
    logic [63:0]      w_bit_len;

    assign w_pos       = r_byte_cnt[5:0];
    assign w_cnt_next  = r_byte_cnt + LEN_W'(1);
    assign w_last_byte = (w_cnt_next == r_len);

`ifdef SHA_PAD_LEN_CHECK_EN
    assign w_len_bad = (msg_length > LEN_W'(MAX_MESSAGE_LENGTH));
`else
    assign w_len_bad = 1'b0;
`endif
    assign w_start_ok = (r_state == IDLE) && start && !w_len_bad;

    always_comb begin
        w_fill_blk = r_buf;
        w_fill_blk[{~w_pos, 3'b000} +: 8] = msg_data;
    end

    // One tail inserter serves the last data byte, the extra block and the empty message
    always_comb begin
        w_tail_in = '0;
        w_pad_pos = '0;
        w_pad_en  = r_pad_pend;
        w_bit_len = 64'({r_len, 3'b000});
        if (r_state == FILL) begin
            w_tail_in = w_fill_blk;
            w_pad_pos = {1'b0, w_pos} + 7'd1;
            w_pad_en  = 1'b1;
        end else if (r_state == IDLE) begin
            w_pad_en  = 1'b1;
            w_bit_len = 64'({msg_length, 3'b000});
        end
    end

    sha_pad_tail u_tail (
        .blk_in     (w_tail_in),
        .pad_pos    (w_pad_pos),
        .pad_en     (w_pad_en),
        .bit_len    (w_bit_len),
        .blk_out    (w_tail_out),
        .need_extra (w_need_extra)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && w_len_bad) begin
                    w_err_nxt = 1'b1;
                end else if (w_start_ok) begin
                    w_state_nxt = (msg_length == '0) ? HOLD : FILL;
                end
            end
            FILL: begin
                if (msg_valid && (w_last_byte || (w_pos == 6'd63))) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (blk_ready) begin
                    if (r_last)           w_state_nxt = IDLE;
                    else if (r_xtra_pend) w_state_nxt = XTRA;
                    else                  w_state_nxt = FILL;
                end
            end
            XTRA:    w_state_nxt = HOLD;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf       <= '0;
            r_len       <= '0;
            r_byte_cnt  <= '0;
            r_blk_cnt   <= '0;
            r_last      <= 1'b0;
            r_xtra_pend <= 1'b0;
            r_pad_pend  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_len       <= msg_length;
                        r_byte_cnt  <= '0;
                        r_blk_cnt   <= '0;
                        r_xtra_pend <= 1'b0;
                        r_pad_pend  <= 1'b0;
                        r_last      <= (msg_length == '0);
                        if (msg_length == '0) begin
                            r_buf <= w_tail_out;
                        end
                    end
                end
                FILL: begin
                    if (msg_valid) begin
                        r_byte_cnt <= w_cnt_next;
                        if (w_last_byte) begin
                            r_buf       <= w_tail_out;
                            r_last      <= !w_need_extra;
                            r_xtra_pend <= w_need_extra;
                            r_pad_pend  <= (w_pos == 6'd63);
                        end else begin
                            r_buf <= w_fill_blk;
                        end
                    end
                end
                HOLD: begin
                    if (blk_ready) begin
                        r_buf     <= '0;
                        r_blk_cnt <= r_blk_cnt + LEN_W'(1);
                        r_last    <= 1'b0;
                    end
                end
                XTRA: begin
                    r_buf       <= w_tail_out;
                    r_last      <= 1'b1;
                    r_xtra_pend <= 1'b0;
                    r_pad_pend  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SHA_PAD_LEN_CHECK_EN
    logic r_err;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_err <= 1'b0;
        else          r_err <= w_err_nxt;
    end
    assign err = r_err;
`endif

    assign blk_data  = r_buf;
    assign blk_valid = (r_state == HOLD);
    assign blk_last  = r_last;
    assign msg_ready = (r_state == FILL);
    assign busy      = (r_state != IDLE);

endmodule : sha_block_padder
`default_nettype wire

// File: tb/tb_sha_block_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_block_padder
// Brief    : Directed, table-driven self-checking bench for sha_block_padder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha_block_padder;

    localparam int MAXLEN = 1024;
    localparam int LW     = $clog2(MAXLEN + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] msg_length = '0;
    logic [7:0]    msg_data = '0;
    logic          msg_valid = 1'b0;
    logic          msg_ready;
    logic [511:0]  blk_data;
    logic          blk_valid;
    logic          blk_ready = 1'b0;
    logic          blk_last;
    logic          busy;
`ifdef SHA_PAD_LEN_CHECK_EN
    logic          err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [511:0] last_blk;

    sha_block_padder #(.MAX_MESSAGE_LENGTH(MAXLEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .msg_length (msg_length),
        .msg_data   (msg_data),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .blk_data   (blk_data),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_last   (blk_last),
`ifdef SHA_PAD_LEN_CHECK_EN
        .err        (err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        int          nblk;
        int          pblk;
        int          ppos;
        logic [63:0] lenf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [519:0] act, input logic [519:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i + 97);
    endfunction

    // Reference block built from the hand-computed pad position and length field
    function automatic logic [511:0] exp_blk(input vec_t v, input int j);
        logic [511:0] r;
        logic [7:0]   b8;
        r = '0;
        for (int b = 0; b < 64; b++) begin
            int g;
            g = 64 * j + b;
            if (g < v.len)                        b8 = pat(g);
            else if (j == v.pblk && b == v.ppos)  b8 = 8'h80;
            else if (j == v.nblk - 1 && b >= 56)  b8 = v.lenf[8 * (63 - b) +: 8];
            else                                  b8 = 8'h00;
            r[511 - 8 * b -: 8] = b8;
        end
        return r;
    endfunction

    task automatic run_msg(input vec_t v);
        int idx, blk, cyc;
        logic         prev_stall;
        logic [511:0] prev_blk;
        logic         prev_last;
        idx = 0; blk = 0; cyc = 0; prev_stall = 1'b0; prev_blk = '0; prev_last = 1'b0;
        start = 1'b1;
        msg_length = LW'(v.len);
        @(negedge clk);
        start = 1'b0;
        while (blk < v.nblk && cyc < 20000) begin
            msg_length = LW'(v.len);
            start      = 1'b0;
            if (cyc == 3 && idx < v.len) begin
                start      = 1'b1;
                msg_length = LW'(5);
            end
            msg_valid = (idx < v.len) && ($urandom_range(0, 3) != 0);
            msg_data  = (idx < v.len) ? pat(idx) : 8'hEE;
            blk_ready = ($urandom_range(0, 2) != 0);
            if (prev_stall) begin
                chk("stall_hold", {6'd0, blk_valid, blk_last, blk_data},
                    {6'd0, 1'b1, prev_last, prev_blk});
            end
            prev_stall = blk_valid && !blk_ready;
            prev_blk   = blk_data;
            prev_last  = blk_last;
            if (msg_valid && msg_ready) idx++;
            if (blk_valid && blk_ready) begin
                chk($sformatf("blk_data len%0d b%0d", v.len, blk), {8'd0, blk_data},
                    {8'd0, exp_blk(v, blk)});
                chk($sformatf("blk_last len%0d b%0d", v.len, blk), 520'(blk_last),
                    520'(blk == v.nblk - 1));
                last_blk = blk_data;
                blk++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; msg_valid = 1'b0; blk_ready = 1'b0;
        if (blk < v.nblk) begin
            chk($sformatf("timeout len%0d blocks", v.len), 520'(blk), 520'(v.nblk));
        end
        chk($sformatf("bytes_taken len%0d", v.len), 520'(idx), 520'(v.len));
        chk($sformatf("idle_after len%0d", v.len), 520'(busy), 520'(0));
    endtask

    initial begin
        vecs[0] = '{len: 3,    nblk: 1,  pblk: 0,  ppos: 3,  lenf: 64'h18};
        vecs[1] = '{len: 55,   nblk: 1,  pblk: 0,  ppos: 55, lenf: 64'h1B8};
        vecs[2] = '{len: 56,   nblk: 2,  pblk: 0,  ppos: 56, lenf: 64'h1C0};
        vecs[3] = '{len: 64,   nblk: 2,  pblk: 1,  ppos: 0,  lenf: 64'h200};
        vecs[4] = '{len: 0,    nblk: 1,  pblk: 0,  ppos: 0,  lenf: 64'h0};
        vecs[5] = '{len: 100,  nblk: 2,  pblk: 1,  ppos: 36, lenf: 64'h320};
        vecs[6] = '{len: 119,  nblk: 2,  pblk: 1,  ppos: 55, lenf: 64'h3B8};
        vecs[7] = '{len: 120,  nblk: 3,  pblk: 1,  ppos: 56, lenf: 64'h3C0};
        vecs[8] = '{len: 127,  nblk: 3,  pblk: 1,  ppos: 63, lenf: 64'h3F8};
        vecs[9] = '{len: 1024, nblk: 17, pblk: 16, ppos: 0,  lenf: 64'h2000};

        repeat (2) @(negedge clk);
        chk("reset_state", {5'd0, blk_valid, blk_last, msg_ready, busy, blk_data}, '0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 10; k++) begin
            run_msg(vecs[k]);
            if (k == 0) begin
                chk("abc_word0", 520'(last_blk[511:480]), 520'(32'h61626380));
                chk("abc_mid", 520'(last_blk[479:32]), '0);
                chk("abc_word15", 520'(last_blk[31:0]), 520'(32'h18));
            end
        end

        // Empty message held under backpressure
        start = 1'b1; msg_length = '0;
        @(negedge clk);
        start = 1'b0;
        msg_valid = 1'b1; msg_data = 8'h5A;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("len0_hold c%0d", c),
                {5'd0, blk_valid, blk_last, msg_ready, busy, blk_data},
                {5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 504'd0});
            @(negedge clk);
        end
        msg_valid = 1'b0;
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        chk("len0_done", 520'({busy, blk_valid}), '0);

        // Reset in the middle of a 100-byte message
        start = 1'b1; msg_length = LW'(100);
        @(negedge clk);
        start = 1'b0;
        begin
            int idx, cyc;
            idx = 0; cyc = 0;
            while (idx < 20 && cyc < 200) begin
                msg_valid = 1'b1;
                msg_data  = pat(idx);
                if (msg_ready) idx++;
                @(negedge clk);
                cyc++;
            end
            chk("mid_fill_bytes", 520'(idx), 520'(20));
        end
        msg_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {5'd0, blk_valid, blk_last, msg_ready, busy, blk_data}, '0);
        @(negedge clk);
        chk("reset_next", {5'd0, blk_valid, blk_last, msg_ready, busy, blk_data}, '0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("no_block_after_reset", 520'({blk_valid, busy}), '0);
        run_msg(vecs[0]);
        chk("post_reset_abc", {8'd0, last_blk},
            {8'd0, 32'h61626380, 448'd0, 32'h18});

`ifdef SHA_PAD_LEN_CHECK_EN
        start = 1'b1; msg_length = LW'(MAXLEN + 1);
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 520'({err, busy, blk_valid}), 520'(3'b100));
        @(negedge clk);
        chk("err_clear", 520'({err, busy, blk_valid}), '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sha_block_padder
`default_nettype wire
